// File: rtl/data_cache_if.sv
// -----------------------------------------------------------------------------
// data_cache_if
// Bundles the CPU-side request/response signals and the memory-side
// fill/write signals of the data cache.
//   slave  : the cache's view (takes CPU requests, issues memory requests)
//   master : the environment's view (CPU driving requests, memory answering)
// Signals:
//   cpu_read/cpu_write/cpu_addr/cpu_wdata  CPU request
//   cpu_rdata/cpu_ready                    CPU response (ready=0 means stall)
//   mem_read/mem_write/mem_addr/mem_wdata  memory request
//   mem_rdata/mem_ready                    memory response (whole line on fill)
// -----------------------------------------------------------------------------
interface data_cache_if #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4
);
    logic                            cpu_read;
    logic                            cpu_write;
    logic [WORD_SIZE-1:0]            cpu_addr;
    logic [WORD_SIZE-1:0]            cpu_wdata;
    logic [WORD_SIZE-1:0]            cpu_rdata;
    logic                            cpu_ready;
    logic                            mem_read;
    logic                            mem_write;
    logic [WORD_SIZE-1:0]            mem_addr;
    logic [WORD_SIZE-1:0]            mem_wdata;
    logic [LINE_WORDS*WORD_SIZE-1:0] mem_rdata;
    logic                            mem_ready;

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        output cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
        input  cpu_rdata, cpu_ready, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
// Direct-mapped, write-through, no-write-allocate data cache between the
// CPU MEM stage and a multi-cycle data memory.
//   clk      clock
//   reset_n  synchronous active-low reset
//   bus      data_cache_if.slave (CPU request/response, memory request/response)
// Optional build macro CACHE_STATS_EN adds saturating counters:
//   access_count  completed CPU requests
//   hit_count     reads that hit on their first IDLE cycle, plus write hits
// Read hits complete in the request cycle; read misses fill a whole line and
// complete on the IDLE cycle following mem_ready; writes always go to memory
// and update the cached word only when the line is present.
// CPU request signals are used live; the CPU holds them while cpu_ready = 0.
// -----------------------------------------------------------------------------
module data_cache #(
    parameter int WORD_SIZE  = 16,
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    data_cache_if.slave          bus
`ifdef CACHE_STATS_EN
    ,
    output logic [WORD_SIZE-1:0] access_count,
    output logic [WORD_SIZE-1:0] hit_count
`endif
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = WORD_SIZE - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e                 state_q;
    logic                   mem_read_q;
    logic                   mem_write_q;
    logic [NUM_LINES-1:0]   valid_q;
    logic [TAG_W-1:0]       tag_q  [NUM_LINES];
    logic [WORD_SIZE-1:0]   data_q [NUM_LINES][LINE_WORDS];

    logic [TAG_W-1:0]       tag_s;
    logic [IDX_W-1:0]       idx_s;
    logic [OFF_W-1:0]       off_s;
    logic                   hit_s;

    // Address split and hit detection on the live CPU address
    always_comb begin
        tag_s = bus.cpu_addr[WORD_SIZE-1 -: TAG_W];
        idx_s = bus.cpu_addr[OFF_W +: IDX_W];
        off_s = bus.cpu_addr[OFF_W-1:0];
        hit_s = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
    end

    // CPU response and memory address/data; held at reset values while reset_n is low
    always_comb begin
        bus.cpu_ready = 1'b1;
        bus.cpu_rdata = {WORD_SIZE{1'b0}};
        bus.mem_addr  = {WORD_SIZE{1'b0}};
        bus.mem_wdata = {WORD_SIZE{1'b0}};
        if (!reset_n) begin
            bus.cpu_ready = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    // A write always goes to memory; a read stalls only on a miss
                    bus.cpu_ready = !bus.cpu_write && !(bus.cpu_read && !hit_s);
                    if (bus.cpu_read && !bus.cpu_write && hit_s) begin
                        bus.cpu_rdata = data_q[idx_s][off_s];
                    end else begin
                        bus.cpu_rdata = {WORD_SIZE{1'b0}};
                    end
                end
                FILL: begin
                    bus.cpu_ready = 1'b0;
                    bus.mem_addr  = {bus.cpu_addr[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
                end
                WRITE: begin
                    bus.cpu_ready = bus.mem_ready;
                    bus.mem_addr  = bus.cpu_addr;
                    bus.mem_wdata = bus.cpu_wdata;
                end
                default: begin
                    bus.cpu_ready = 1'b1;
                end
            endcase
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;

    // Controller FSM: state, registered memory strobes, tags and valid bits
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            valid_q     <= {NUM_LINES{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cpu_write) begin
                        state_q     <= WRITE;
                        mem_write_q <= 1'b1;
                    end else if (bus.cpu_read && !hit_s) begin
                        state_q    <= FILL;
                        mem_read_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                FILL: begin
                    if (bus.mem_ready) begin
                        state_q        <= IDLE;
                        mem_read_q     <= 1'b0;
                        valid_q[idx_s] <= 1'b1;
                        tag_q[idx_s]   <= tag_s;
                    end else begin
                        state_q <= FILL;
                    end
                end
                WRITE: begin
                    if (bus.mem_ready) begin
                        state_q     <= IDLE;
                        mem_write_q <= 1'b0;
                    end else begin
                        state_q <= WRITE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // Line data: whole-line fill, or single-word update on a write hit (no allocate on miss)
    always_ff @(posedge clk) begin
        if (reset_n && state_q == FILL && bus.mem_ready) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                data_q[idx_s][k] <= bus.mem_rdata[k*WORD_SIZE +: WORD_SIZE];
            end
        end else if (reset_n && state_q == WRITE && bus.mem_ready && hit_s) begin
            data_q[idx_s][off_s] <= bus.cpu_wdata;
        end
    end

`ifdef CACHE_STATS_EN
    logic fill_done_q;
    logic done_s;
    logic hit_evt_s;

    // A completed request, and whether it counts as a hit; the read right after a fill does not
    always_comb begin
        done_s    = reset_n && bus.cpu_ready && (bus.cpu_read || bus.cpu_write);
        hit_evt_s = done_s &&
                    ((state_q == IDLE && !bus.cpu_write && !fill_done_q) ||
                     (state_q == WRITE && hit_s));
    end

    // Saturating statistics counters and the post-fill marker
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fill_done_q  <= 1'b0;
            access_count <= {WORD_SIZE{1'b0}};
            hit_count    <= {WORD_SIZE{1'b0}};
        end else begin
            fill_done_q <= (state_q == FILL) && bus.mem_ready;
            if (done_s && access_count != {WORD_SIZE{1'b1}}) begin
                access_count <= access_count + WORD_SIZE'(1);
            end else begin
                access_count <= access_count;
            end
            if (hit_evt_s && hit_count != {WORD_SIZE{1'b1}}) begin
                hit_count <= hit_count + WORD_SIZE'(1);
            end else begin
                hit_count <= hit_count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// -----------------------------------------------------------------------------
// tb_data_cache
// Directed vectors drive CPU requests; expected read data, fill addresses and
// memory writes are pushed into queues and checked by separate monitors when
// the DUT completes a CPU request or the memory model completes a transfer.
// The memory model answers each request after MEM_LAT cycles.
// -----------------------------------------------------------------------------
module tb_data_cache;
    localparam int WS      = 16;
    localparam int LW      = 4;
    localparam int MEM_LAT = 3;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    data_cache_if #(.WORD_SIZE(WS), .LINE_WORDS(LW)) bus ();

`ifdef CACHE_STATS_EN
    logic [WS-1:0] access_count;
    logic [WS-1:0] hit_count;
`endif

    data_cache #(.WORD_SIZE(WS), .LINE_WORDS(LW), .NUM_LINES(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
`ifdef CACHE_STATS_EN
        ,
        .access_count (access_count),
        .hit_count    (hit_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit        is_write;
        logic [WS-1:0] rdata;
    } resp_t;

    resp_t             resp_q[$];
    logic [WS-1:0]     fill_q[$];
    logic [2*WS-1:0]   wr_q[$];
    logic [WS-1:0]     bench_mem[int];

    function automatic logic [WS-1:0] get_word(input logic [WS-1:0] a);
        if (bench_mem.exists(int'(a))) return bench_mem[int'(a)];
        return a ^ 16'hA5A5;
    endfunction

    // Memory model: counts request cycles and answers on the MEM_LAT-th one
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_read || bus.mem_write) begin
                cnt = cnt + 1;
                bus.mem_ready = (cnt == MEM_LAT);
                if (bus.mem_ready && bus.mem_read) begin
                    for (int k = 0; k < LW; k++)
                        bus.mem_rdata[k*WS +: WS] = get_word(bus.mem_addr + 16'(k));
                end
                if (bus.mem_ready && bus.mem_write)
                    bench_mem[int'(bus.mem_addr)] = bus.mem_wdata;
            end else begin
                cnt = 0;
                bus.mem_ready = 1'b0;
            end
        end
    end

    // CPU-side monitor: pops the expected response on each completed request
    always @(negedge clk) begin
        resp_t r;
        if (reset_n && bus.cpu_ready && (bus.cpu_read || bus.cpu_write)) begin
            checks++;
            if (resp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected addr=%h", bus.cpu_addr);
            end else begin
                r = resp_q.pop_front();
                if (!r.is_write && bus.cpu_rdata !== r.rdata) begin
                    errors++;
                    $display("FAIL rdata addr=%h got=%h exp=%h", bus.cpu_addr, bus.cpu_rdata, r.rdata);
                end
            end
        end
    end

    // Memory-side monitor: fill addresses, write address/data, exclusive strobes
    always @(negedge clk) begin
        logic [2*WS-1:0] w;
        logic [WS-1:0]   f;
        if (bus.mem_read && bus.mem_write) begin
            checks++;
            errors++;
            $display("FAIL mem_exclusive got=both exp=one");
        end
        if (bus.mem_ready && bus.mem_read) begin
            checks++;
            if (fill_q.size() == 0) begin
                errors++;
                $display("FAIL fill_unexpected got=%h exp=none", bus.mem_addr);
            end else begin
                f = fill_q.pop_front();
                if (bus.mem_addr !== f) begin
                    errors++;
                    $display("FAIL fill_addr got=%h exp=%h", bus.mem_addr, f);
                end
            end
        end
        if (bus.mem_ready && bus.mem_write) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected got=%h exp=none", bus.mem_addr);
            end else begin
                w = wr_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== w) begin
                    errors++;
                    $display("FAIL mem_write got=%h/%h exp=%h/%h",
                             bus.mem_addr, bus.mem_wdata, w[2*WS-1:WS], w[WS-1:0]);
                end
            end
        end
    end

    typedef struct {
        bit        rd;
        bit        wr;
        logic [WS-1:0] addr;
        logic [WS-1:0] wdata;
        logic [WS-1:0] exp_rdata;
        int        exp_cyc;
        bit        exp_fill;
    } vec_t;

    // Issue one request, queue its expectations, and check stall length
    task automatic do_req(input vec_t v);
        resp_t r;
        int cyc;
        r.is_write = v.wr;
        r.rdata    = v.exp_rdata;
        resp_q.push_back(r);
        if (v.exp_fill) fill_q.push_back({v.addr[WS-1:2], 2'b00});
        if (v.wr) wr_q.push_back({v.addr, v.wdata});
        @(posedge clk);
        #1;
        bus.cpu_read  = v.rd;
        bus.cpu_write = v.wr;
        bus.cpu_addr  = v.addr;
        bus.cpu_wdata = v.wdata;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (bus.cpu_ready) break;
            cyc++;
            if (cyc > 40) break;
        end
        checks++;
        if (cyc != v.exp_cyc) begin
            errors++;
            $display("FAIL stall_cycles addr=%h got=%0d exp=%0d", v.addr, cyc, v.exp_cyc);
        end
        @(posedge clk);
        #1;
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    task automatic chk(input string name, input logic [WS-1:0] got, input logic [WS-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    vec_t vecs[13];

    initial begin
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        for (int k = 0; k < 4; k++) begin
            bench_mem[16'h0010 + k] = 16'h00D0 + 16'(k);
            bench_mem[16'h0090 + k] = 16'h00E0 + 16'(k);
        end

        // rd wr addr wdata exp_rdata cycles fill
        vecs[0]  = '{1'b1, 1'b0, 16'h0012, 16'h0000, 16'h00D2, 4, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 16'h0013, 16'h0000, 16'h00D3, 0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 16'h0011, 16'hBEEF, 16'h0000, 3, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 16'hBEEF, 0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 16'h0400, 16'h1234, 16'h0000, 3, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 16'h0400, 16'h0000, 16'h1234, 4, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 16'h0090, 16'h0000, 16'h00E0, 4, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h00D0, 4, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 16'hBEEF, 0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 16'h0091, 16'h0000, 16'h00E1, 4, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 16'h0013, 16'h5555, 16'h0000, 3, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 16'h0093, 16'h0000, 16'h00E3, 0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 16'h0013, 16'h0000, 16'h5555, 4, 1'b1};

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_cpu_ready", 16'(bus.cpu_ready), 16'h0001);
        chk("rst_mem_read",  16'(bus.mem_read),  16'h0000);
        chk("rst_mem_write", 16'(bus.mem_write), 16'h0000);
        chk("rst_mem_addr",  bus.mem_addr,       16'h0000);
        chk("rst_cpu_rdata", bus.cpu_rdata,      16'h0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) do_req(vecs[i]);

        // Reset in the middle of a fill
        do_reset();
        @(posedge clk);
        #1;
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 16'h0010;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        bus.cpu_read = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midfill_mem_read",  16'(bus.mem_read),  16'h0000);
        chk("midfill_cpu_ready", 16'(bus.cpu_ready), 16'h0001);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        do_req('{1'b1, 1'b0, 16'h0012, 16'h0000, 16'h00D2, 4, 1'b1});

`ifdef CACHE_STATS_EN
        do_reset();
        chk("stats_reset_access", access_count, 16'h0000);
        do_req('{1'b1, 1'b0, 16'h0010, 16'h0000, 16'h00D0, 4, 1'b1});
        do_req('{1'b1, 1'b0, 16'h0011, 16'h0000, 16'hBEEF, 0, 1'b0});
        do_req('{1'b0, 1'b1, 16'h0011, 16'h7777, 16'h0000, 3, 1'b0});
        do_req('{1'b1, 1'b0, 16'h0400, 16'h0000, 16'h1234, 4, 1'b1});
        @(negedge clk);
        chk("stats_access", access_count, 16'h0004);
        chk("stats_hit",    hit_count,    16'h0002);
`endif

        repeat (8) @(posedge clk);
        chk("resp_q_left",  16'(resp_q.size()), 16'h0000);
        chk("fill_q_left",  16'(fill_q.size()), 16'h0000);
        chk("write_q_left", 16'(wr_q.size()),   16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-through, no-write-allocate data cache.
- Sits between the pipelined CPU's MEM stage and the multi-cycle data memory.
- Consumes the CPU's data read/write requests and returns read data with a ready/stall handshake.
- Fills whole lines from memory on read misses, so the CPU no longer pays memory latency on every access.

Parameters:
- WORD_SIZE, 16, data/address width in bits.
- LINE_WORDS, 4, words per line (power of 2); offset bits OFF_W = log2(LINE_WORDS).
- NUM_LINES, 8, number of lines (power of 2); index bits IDX_W = log2(NUM_LINES); tag bits = WORD_SIZE-IDX_W-OFF_W.

Ports:
- clk  input  1  clock.
- reset_n  input  1  synchronous active-low reset.
- cpu_read  input  1  CPU load request.
- cpu_write  input  1  CPU store request.
- cpu_addr  input  WORD_SIZE  word address.
- cpu_wdata  input  WORD_SIZE  store data.
- cpu_rdata  output  WORD_SIZE  load data, valid when cpu_ready=1 and cpu_read=1.
- cpu_ready  output  1  request completes this cycle; 0 = CPU must stall.
- mem_read  output  1  line fill request.
- mem_write  output  1  single-word write request.
- mem_addr  output  WORD_SIZE  memory word address.
- mem_wdata  output  WORD_SIZE  write data to memory.
- mem_rdata  input  LINE_WORDS*WORD_SIZE  fill line; word k at bits [k*WORD_SIZE +: WORD_SIZE].
- mem_ready  input  1  memory completes current request this cycle.

Behaviour:
- Reset: reset_n, clk; reset is synchronous and active-low.
  - On reset all valid bits clear and the FSM goes to IDLE.
  - All mem_* outputs go to 0; cpu_rdata = 0; cpu_ready = 1 (no request pending).
  - Reset mid-fill or mid-write abandons the transaction; a mem_ready arriving later is ignored.
- Address split: tag = addr[WS-1 : IDX_W+OFF_W], index = addr[IDX_W+OFF_W-1 : OFF_W], offset = addr[OFF_W-1:0].
- Hit: valid[index] && tag_array[index] == tag.
- State IDLE:
  - No request: cpu_ready = 1.
  - Read hit: cpu_ready = 1 in the same cycle; cpu_rdata = line[index][offset] combinationally. Zero extra latency.
  - Read miss: cpu_ready = 0 → FILL.
  - Write (hit or miss): cpu_ready = 0 → WRITE.
  - cpu_read && cpu_write together: treated as a write.
- State FILL:
  - mem_read = 1; mem_addr = cpu_addr with offset bits zeroed; held stable until mem_ready.
  - On the mem_ready cycle: write the whole line, set tag and valid → IDLE. cpu_ready stays 0 in that cycle.
  - The next cycle is an IDLE hit, so a read miss completes on cycle (memory latency + 1).
- State WRITE:
  - mem_write = 1; mem_addr = cpu_addr; mem_wdata = cpu_wdata; held until mem_ready.
  - cpu_ready = mem_ready. On that cycle, if the access is a hit, update only the addressed word in the line → IDLE.
  - On a miss, no line is allocated (no-write-allocate).
- CPU contract: cpu_read, cpu_write, cpu_addr and cpu_wdata stay stable while cpu_ready = 0. The cache samples them live and does not latch them.
- Never asserts mem_read and mem_write together; mem_* are 0 in IDLE.
- A conflicting line is replaced without writeback; write-through keeps memory current.
- Index wrap: addresses differing only in tag map to the same line and evict each other.

Optional Feature:
- Macro CACHE_STATS_EN.
- When defined, adds outputs access_count[WORD_SIZE-1:0] and hit_count[WORD_SIZE-1:0]; both reset to 0.
  - access_count increments once per completed CPU request (cpu_ready = 1 with cpu_read or cpu_write).
  - hit_count increments on a completed read that was a hit on its first IDLE cycle, or a write that hit.
  - A read completing after a fill is not counted as a hit.
  - Both counters saturate at all-ones.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Cold read miss: after reset, read addr 0x0012 with memory latency 3 and line {0xD3,0xD2,0xD1,0xD0} → mem_read with mem_addr = 0x0010 for 3 cycles. cpu_ready = 1 one cycle after mem_ready, with cpu_rdata = 0xD2. A following read of 0x0013 hits in 1 cycle with 0xD3.
- Write hit: after filling 0x0010, write 0x0011 ← 0xBEEF → mem_write, mem_addr = 0x0011, mem_wdata = 0xBEEF until mem_ready, then cpu_ready = 1. A read of 0x0011 then hits with 0xBEEF and mem_read stays 0.
- Write miss: write 0x0400 ← 0x1234 into an empty cache → a single memory write only. A later read of 0x0400 misses, i.e. mem_read is asserted.
- Conflict eviction: read 0x0010, then 0x0090 (same index 4, different tag), then 0x0010 → three fills. The final read returns the original data.
- Reset mid-fill: assert reset_n = 0 while in FILL → next cycle mem_read = 0 and cpu_ready = 1. A read of 0x0010 then misses again.
- Stats (CACHE_STATS_EN): run the sequence 0x0010 read, 0x0011 read, 0x0011 write, 0x0400 read → access_count = 4, hit_count = 2.
